// File: rtl/hex_pair_dimmer.sv
// PWM dimmer and optional blinker for a two-digit active-low 7-segment display.
// Blinking is built only when HEX_PAIR_DIMMER_BLINK_EN is defined.
module hex_pair_dimmer #(
    parameter int unsigned PRESCALE     = 195,
    parameter int unsigned BLINK_FRAMES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] seg_in,
    input  logic [3:0]  level0,
    input  logic [3:0]  level1,
    input  logic [1:0]  blink,
    output logic [6:0]  hex0_n,
    output logic [6:0]  hex1_n,
    output logic        frame_tick
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [3:0]  pwm_cnt_q, pwm_cnt_d;
    logic [13:0] sh_seg_q, sh_seg_d;
    logic [3:0]  sh_lvl0_q, sh_lvl0_d;
    logic [3:0]  sh_lvl1_q, sh_lvl1_d;
    logic [6:0]  hex0_q, hex0_d;
    logic [6:0]  hex1_q, hex1_d;
    logic        frame_tick_q, frame_tick_d;
    logic        step, frame_end;
    logic        on0, on1;
    logic [1:0]  blanked;

    assign step      = (pre_cnt_q == PRE_LAST);
    assign frame_end = step && (pwm_cnt_q == 4'hF);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pre_cnt_d    = step ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d    = step ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
        sh_seg_d     = sh_seg_q;
        sh_lvl0_d    = sh_lvl0_q;
        sh_lvl1_d    = sh_lvl1_q;
        frame_tick_d = frame_end;
        if (frame_end) begin
            sh_seg_d  = seg_in;
            sh_lvl0_d = level0;
            sh_lvl1_d = level1;
        end
    end

`ifdef HEX_PAIR_DIMMER_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [1:0]  sh_blink_q, sh_blink_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        sh_blink_d    = sh_blink_q;
        if (frame_end) begin
            sh_blink_d = blink;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 16'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= 16'd0;
            blink_phase_q <= 1'b0;
            sh_blink_q    <= 2'b00;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_blink_q    <= sh_blink_d;
        end
    end

    assign blanked = blink_phase_q ? sh_blink_q : 2'b00;
`else
    logic unused_blink;
    assign unused_blink = ^{blink, BLINK_FRAMES};
    assign blanked      = 2'b00;
`endif

    // Lit for the first L PWM steps of each frame; level 15 forces lit all frame.
    always_comb begin
        on0    = (sh_lvl0_q == 4'hF) || (pwm_cnt_q < sh_lvl0_q);
        on1    = (sh_lvl1_q == 4'hF) || (pwm_cnt_q < sh_lvl1_q);
        hex0_d = (on0 && !blanked[0]) ? sh_seg_q[6:0]  : 7'h7F;
        hex1_d = (on1 && !blanked[1]) ? sh_seg_q[13:7] : 7'h7F;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: shadow registers reset to a dark display so nothing lights before the first frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q    <= 16'd0;
            pwm_cnt_q    <= 4'd0;
            sh_seg_q     <= 14'h3FFF;
            sh_lvl0_q    <= 4'd0;
            sh_lvl1_q    <= 4'd0;
            hex0_q       <= 7'h7F;
            hex1_q       <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            sh_seg_q     <= sh_seg_d;
            sh_lvl0_q    <= sh_lvl0_d;
            sh_lvl1_q    <= sh_lvl1_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hex0_n     = hex0_q;
    assign hex1_n     = hex1_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_pair_dimmer.sv
// Self-checking bench for hex_pair_dimmer (PRESCALE=2, BLINK_FRAMES=2); blink checks follow
// HEX_PAIR_DIMMER_BLINK_EN.
module tb_hex_pair_dimmer;

    localparam int P     = 2;
    localparam int BF    = 2;
    localparam int FRAME = 16 * P;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] seg_in = 14'h3FFF;
    logic [3:0]  level0 = 4'd0;
    logic [3:0]  level1 = 4'd0;
    logic [1:0]  blink = 2'b00;
    logic [6:0]  hex0_n, hex1_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    hex_pair_dimmer #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .level0     (level0),
        .level1     (level1),
        .blink      (blink),
        .hex0_n     (hex0_n),
        .hex1_n     (hex1_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derived from the edge count since reset release.
    // Output after edge e reflects the frame position reached at edge e-1; inputs are
    // captured at every edge that is a multiple of the frame length.
    int          n;
    logic [13:0] m_seg;
    logic [3:0]  m_l0, m_l1;
    logic [1:0]  m_blk;
    logic [6:0]  e_h0, e_h1;
    logic        e_tick;
    bit          model_on = 1'b0;

    function automatic logic [6:0] ref_digit(input logic [6:0] seg, input int lvl,
                                             input logic blk, input int t);
        int  pos   = t % FRAME;
        int  phase = ((t / FRAME) / BF) % 2;
        bit  lit   = (lvl == 15) || (pos < lvl * P);
`ifdef HEX_PAIR_DIMMER_BLINK_EN
        if (blk && phase == 1) lit = 1'b0;
`else
        if (blk && phase == 2) lit = 1'b0;
`endif
        return lit ? seg : 7'h7F;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n      <= 0;
            m_seg  <= 14'h3FFF;
            m_l0   <= 4'd0;
            m_l1   <= 4'd0;
            m_blk  <= 2'b00;
            e_h0   <= 7'h7F;
            e_h1   <= 7'h7F;
            e_tick <= 1'b0;
        end else begin
            n      <= n + 1;
            e_h0   <= ref_digit(m_seg[6:0],  int'(m_l0), m_blk[0], n);
            e_h1   <= ref_digit(m_seg[13:7], int'(m_l1), m_blk[1], n);
            e_tick <= ((n + 1) % FRAME == 0);
            if ((n + 1) % FRAME == 0) begin
                m_seg <= seg_in;
                m_l0  <= level0;
                m_l1  <= level1;
                m_blk <= blink;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_hex0", hex0_n, e_h0);
            check("model_hex1", hex1_n, e_h1);
            check("model_tick", frame_tick, e_tick);
        end
    end

    // Waits for the next frame_tick (bounded); returns negedges waited.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_tick && cyc < 200);
        check("tick_seen", frame_tick, 1'b1);
    endtask

    typedef struct {
        logic [13:0] seg;
        logic [3:0]  l0;
        logic [3:0]  l1;
        int          step;
        logic [6:0]  h0;
        logic [6:0]  h1;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  c;
        int  lit_cnt;
        int  first_lit;
        bit  exp_lit;

        vecs[0] = '{14'h0040, 4'd15, 4'd15, 0,  7'h40, 7'h00};
        vecs[1] = '{14'h0040, 4'd15, 4'd15, 15, 7'h40, 7'h00};
        vecs[2] = '{14'h3F79, 4'd4,  4'd0,  3,  7'h79, 7'h7F};
        vecs[3] = '{14'h3F79, 4'd4,  4'd0,  4,  7'h7F, 7'h7F};
        vecs[4] = '{14'h1234, 4'd1,  4'd14, 0,  7'h34, 7'h24};
        vecs[5] = '{14'h1234, 4'd1,  4'd14, 1,  7'h7F, 7'h24};
        vecs[6] = '{14'h1234, 4'd1,  4'd14, 13, 7'h7F, 7'h24};
        vecs[7] = '{14'h1234, 4'd1,  4'd14, 14, 7'h7F, 7'h7F};
        vecs[8] = '{14'h0000, 4'd0,  4'd8,  7,  7'h7F, 7'h00};
        vecs[9] = '{14'h0000, 4'd0,  4'd8,  8,  7'h7F, 7'h7F};

        // Reset default and first frame timing
        repeat (3) @(negedge clk);
        check("rst_hex0", hex0_n, 7'h7F);
        check("rst_hex1", hex1_n, 7'h7F);
        check("rst_tick", frame_tick, 1'b0);
        model_on = 1'b1;
        reset_n  = 1'b1;
        wait_tick(c);
        check("first_tick_delay", c, FRAME);
        check("dark_after_reset", hex0_n, 7'h7F);

        // Table-driven brightness vectors
        for (int i = 0; i < 10; i++) begin
            seg_in = vecs[i].seg;
            level0 = vecs[i].l0;
            level1 = vecs[i].l1;
            blink  = 2'b00;
            wait_tick(c);
            repeat (vecs[i].step * P + 1) @(negedge clk);
            check($sformatf("vec%0d_hex0", i), hex0_n, vecs[i].h0);
            check($sformatf("vec%0d_hex1", i), hex1_n, vecs[i].h1);
        end

        // Duty cycle: level 4 lit for 8 of 32 clocks, starting 1 clock after frame_tick
        seg_in = 14'h0040; level0 = 4'd4; level1 = 4'd15;
        wait_tick(c);
        lit_cnt = 0; first_lit = -1;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (hex0_n == 7'h40) begin
                lit_cnt++;
                if (first_lit < 0) first_lit = k;
            end
        end
        check("duty4_count", lit_cnt, 8);
        check("duty4_start", first_lit, 1);
        level0 = 4'd0;
        wait_tick(c);
        lit_cnt = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (hex0_n != 7'h7F) lit_cnt++;
        end
        check("duty0_count", lit_cnt, 0);

        // Tearing: mid-frame change held until the next frame end
        seg_in = 14'h0040; level0 = 4'd15; level1 = 4'd15;
        wait_tick(c);
        wait_tick(c);
        repeat (7 * P + 1) @(negedge clk);
        seg_in = 14'h3F79;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            check("tear_hold_hex0", hex0_n, 7'h40);
        end while (!frame_tick && c < 40);
        check("tear_tick", frame_tick, 1'b1);
        @(negedge clk);
        check("tear_new_hex0", hex0_n, 7'h79);
        check("tear_new_hex1", hex1_n, 7'h7E);

        // Change present exactly on the frame_end edge is captured
        wait_tick(c);
        repeat (FRAME - 1) @(negedge clk);
        seg_in = 14'h0040;
        @(negedge clk);
        check("edge_tick", frame_tick, 1'b1);
        @(negedge clk);
        check("edge_hex0", hex0_n, 7'h40);
        check("edge_hex1", hex1_n, 7'h00);

        // Blink: digit0 alternates 2 frames lit / 2 dark, digit1 stays lit
        reset_n = 1'b0;
        seg_in = 14'h0040; level0 = 4'd15; level1 = 4'd15; blink = 2'b01;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_tick(c);
            repeat (5) @(negedge clk);
`ifdef HEX_PAIR_DIMMER_BLINK_EN
            exp_lit = ((k / BF) % 2 == 0);
`else
            exp_lit = 1'b1;
`endif
            check($sformatf("blink_f%0d_hex0", k), hex0_n, exp_lit ? 7'h40 : 7'h7F);
            check($sformatf("blink_f%0d_hex1", k), hex1_n, 7'h00);
        end
        blink = 2'b00;

        // Frame spacing over 1000 frames
        wait_tick(c);
        for (int k = 0; k < 1000; k++) begin
            wait_tick(c);
            check("tick_spacing", c, FRAME);
        end

        // One-cycle reset at pwm step 9 blanks immediately and restarts frame timing
        wait_tick(c);
        repeat (9 * P) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("pulse_rst_hex0", hex0_n, 7'h7F);
        check("pulse_rst_hex1", hex1_n, 7'h7F);
        check("pulse_rst_tick", frame_tick, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_tick(c);
        check("restart_tick_delay", c, FRAME);

        // Randomized inputs checked cycle-by-cycle against the model
        for (int k = 0; k < 300; k++) begin
            seg_in = 14'($urandom);
            level0 = 4'($urandom);
            level1 = 4'($urandom);
            blink  = 2'($urandom);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        model_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_pair_dimmer.md
# hex_pair_dimmer

Downstream stage of the two-digit HEX output PIO. It takes the 14-bit segment word (two 7-segment digits) and adds per-digit PWM brightness and optional blinking before the HEX pins. Input changes are double-buffered and applied only at PWM frame boundaries, so the display never tears mid-frame. It sits between the PIO `out_port` and the board HEX1/HEX0 pins.

## Interface
Parameters:
- `PRESCALE`, default 195: clocks per PWM step, legal range 1..65535. 50 MHz gives about 16 kHz frame rate.
- `BLINK_FRAMES`, default 4096: frames per blink half-period, range 1..65535.

Ports:
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `seg_in`  in  14  segment word from the PIO. [6:0] is digit 0, [13:7] is digit 1. Active-low: 0 lights the segment.
- `level0`, `level1`  in  4  brightness per digit. 0 means off, 15 means fully on.
- `blink`  in  2  per-digit blink enable. Bit 0 is digit 0.
- `hex0_n`, `hex1_n`  out  7  registered segment outputs, active-low.
- `frame_tick`  out  1  one-cycle pulse on every shadow-load edge.

## Operation
- **Prescaler `pre_cnt`**
  - Counts 0..PRESCALE-1 and wraps.
  - `step` = (`pre_cnt` == PRESCALE-1).
- **PWM counter `pwm_cnt` (4 bits)**
  - Increments on `step`, wrapping 15→0.
  - `frame_end` = `step` && `pwm_cnt` == 15.
- **Shadow load**
  - On the `frame_end` edge, `seg_in`, `level0`, `level1` and `blink` are captured into shadow registers.
  - Inputs are sampled only on that edge. Changes at any other time are ignored until the next frame end.
  - A change present on the same edge as `frame_end` is captured.
- **Digit lit condition** (per digit d):
  - `on_d` = (`lvl_d` == 15) || (`pwm_cnt` < `lvl_d`), 4-bit unsigned compare.
  - Level 0 is never lit. Level 15 is always lit. Level L is lit for L of 16 PWM steps.
- **Blink**
  - `blink_cnt` counts `frame_end` events 0..BLINK_FRAMES-1.
  - On wrap, `blink_phase` toggles.
  - While `blink_phase` = 1, any digit with its shadow blink bit set is blanked.
- **Output**
  - `hex_d_n` <= `on_d` && !blanked_d ? shadow segments : 7'h7F.
  - Outputs are registered every clock.
- **Reset** (asynchronous, takes effect mid-frame immediately):
  - `pre_cnt`, `pwm_cnt`, `blink_cnt` and `blink_phase` go to 0.
  - Shadow segments go to 14'h3FFF, shadow levels to 0, shadow blink to 0.
  - `hex0_n` and `hex1_n` go to 7'h7F. `frame_tick` goes to 0.
  - Display stays dark until the first frame end loads real values.

## Timing
- Frame length is exactly 16×PRESCALE clocks. The first `frame_end` after reset release occurs on clock edge 16×PRESCALE.
- `frame_tick` is high for the single cycle following the load edge, registered.
- Output latency: a shadow value loaded at edge E is visible on `hex*_n` after edge E+1. It corresponds to `pwm_cnt` = 0.
- Steady-state duty: for level L in 1..14, the digit is lit for L×PRESCALE clocks per frame, contiguous from the frame start.
- Blink period is 2×BLINK_FRAMES frames. `blink_phase` toggles on the frame-end edge where `blink_cnt` wraps, and that frame's outputs already reflect it.
- PRESCALE = 1: `step` is permanently 1 and the frame is 16 clocks. No other behaviour changes.
- BLINK_FRAMES = 1: the phase toggles every frame.

## Configuration
- Macro: `HEX_PAIR_DIMMER_BLINK_EN`.
- **Defined:** `blink_cnt`, `blink_phase` and shadow blink are implemented as described above.
- **Undefined:**
  - That logic is removed and `blink` is ignored.
  - blanked_d is constant 0 and BLINK_FRAMES is unused.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use PRESCALE = 2 and BLINK_FRAMES = 2 (frame = 32 clocks).
- **Reset default:** assert `reset_n` = 0 mid-frame → `hex0_n`/`hex1_n` go to 7'h7F and stay there. First `frame_tick` arrives 32 clocks after release.
- **Full on:** `seg_in` = 14'h0040 (digit0 shows "0"), level0 = 15, level1 = 15 → after the first frame end, `hex0_n` = 7'h40 and `hex1_n` = 7'h00 continuously.
- **Duty:** level0 = 4 → `hex0_n` shows the pattern for exactly 8 of every 32 clocks, starting 1 clock after `frame_tick`, and is 7'h7F otherwise. level0 = 0 → always 7'h7F.
- **Tearing:** change `seg_in` from 14'h0040 to 14'h3F79 at pwm step 7 → outputs keep the old pattern until the next frame end, then switch.
  - Variant: change `seg_in` on the exact `frame_end` edge → the new value is captured in that frame.
- **Blink** (macro defined): blink = 2'b01 with both levels at 15 → digit0 alternates 2 frames lit / 2 frames 7'h7F; digit1 stays lit. With the macro undefined, both digits stay lit.
- **Wrap and restart:** run 1000 frames and check `frame_tick` spacing is exactly 32. Pulse `reset_n` low for 1 cycle at pwm step 9 → outputs go 7'h7F immediately and frame timing restarts from 0.
